// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   ID-stage hazard detection. It tracks a busy bit per register for
//   in-flight long-latency producers (LOAD/MUL/DIV), the occupancy of the
//   mul/div unit, and the number of outstanding stores for fence.i ordering.
//   It also runs a bubble FSM that holds the pipe for BJ_BUBBLES cycles
//   after a branch/jump is accepted.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   id_*            decoded instruction held in ID
//   wb_valid/addr   per-port writeback clears (port k at wb_addr[k*W +: W])
//   md_done         mul/div result produced
//   st_retire       one store drained to memory
//   flush           pipeline redirect
//   pipe_stall      stall IF/ID
//   raw_risk        RAW/WAW component of the stall
//   sb_full         store count == SB_DEPTH
//   busy_vec        scoreboard state (debug)
//
// Optional: define STALL_PERF_CNT_EN to add the saturating 32-bit counters
//   perf_raw_cnt, perf_struct_cnt and perf_bj_cnt.
//
// BJ FSM states
//   state  | meaning
//   IDLE   | no branch bubble pending
//   BUBBLE | holding stall; bj_cnt_q counts the remaining cycles minus one
module hazard_scoreboard #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int NUM_WB        = 2,
  parameter int SB_DEPTH      = 4,
  parameter int BJ_BUBBLES    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic                              id_rs1_used,
  input  logic                              id_rs2_used,
  input  logic [RF_ADDR_WIDTH-1:0]          id_rs1,
  input  logic [RF_ADDR_WIDTH-1:0]          id_rs2,
  input  logic [RF_ADDR_WIDTH-1:0]          id_rd,
  input  logic                              id_rd_wen,
  input  logic [1:0]                        id_cls,
  input  logic                              id_is_bj,
  input  logic                              id_is_store,
  input  logic                              id_is_fence_i,
  input  logic [NUM_WB-1:0]                 wb_valid,
  input  logic [NUM_WB*RF_ADDR_WIDTH-1:0]   wb_addr,
  input  logic                              md_done,
  input  logic                              st_retire,
  input  logic                              flush,
  output logic                              pipe_stall,
  output logic                              raw_risk,
  output logic                              sb_full,
  output logic [2**RF_ADDR_WIDTH-1:0]       busy_vec
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_raw_cnt,
  output logic [31:0]                       perf_struct_cnt,
  output logic [31:0]                       perf_bj_cnt
`endif
);

  localparam int NUM_REGS  = 2**RF_ADDR_WIDTH;
  localparam int CNT_W     = $clog2(SB_DEPTH + 1);
  localparam int BJ_LOAD_I = (BJ_BUBBLES > 0) ? BJ_BUBBLES - 1 : 0;
  localparam logic [CNT_W-1:0] SB_FULL_VAL = CNT_W'(SB_DEPTH);
  localparam logic [3:0]       BJ_LOAD     = 4'(BJ_LOAD_I);

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_MUL = 2'd2;
  localparam logic [1:0] CLS_DIV = 2'd3;

  typedef enum logic {IDLE, BUBBLE} bj_state_t;

  bj_state_t            state_q, state_d;
  logic [3:0]           bj_cnt_q, bj_cnt_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d, set_mask, clr_mask;
  logic [CNT_W-1:0]     st_cnt_q, st_cnt_d;
  logic                 md_busy_q, md_busy_d;
  logic                 is_md, md_struct, st_struct, fence_stall, accept;
  logic                 st_inc, st_dec;

  assign is_md       = (id_cls == CLS_MUL) || (id_cls == CLS_DIV);
  assign sb_full     = (st_cnt_q == SB_FULL_VAL);
  assign busy_vec    = busy_q;

  // busy_q[0] is held at zero, so an x0 operand never raises a hazard.
  assign raw_risk    = id_valid & ((id_rs1_used & busy_q[id_rs1]) |
                                   (id_rs2_used & busy_q[id_rs2]) |
                                   (id_rd_wen   & busy_q[id_rd]));
  assign md_struct   = id_valid & is_md & md_busy_q;
  assign st_struct   = id_valid & id_is_store & sb_full;
  assign fence_stall = id_valid & id_is_fence_i & (st_cnt_q != '0);
  assign pipe_stall  = raw_risk | md_struct | st_struct | fence_stall |
                       (state_q == BUBBLE);
  assign accept      = id_valid & ~pipe_stall & ~flush;

  // Clears are applied first so a same-cycle set of the same register wins.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) clr_mask[wb_addr[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]] = 1'b1;
    end
    if (accept && id_rd_wen && (id_cls != CLS_ALU) && (id_rd != '0))
      set_mask[id_rd] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    md_busy_d = md_busy_q;
    if (accept && is_md)  md_busy_d = 1'b1;
    else if (md_done)     md_busy_d = 1'b0;
  end

  // A retire with nothing outstanding is dropped so the count cannot wrap.
  assign st_inc = accept & id_is_store;
  assign st_dec = st_retire & (st_cnt_q != '0);

  always_comb begin
    st_cnt_d = st_cnt_q;
    if (st_inc && !st_dec)      st_cnt_d = st_cnt_q + 1'b1;
    else if (!st_inc && st_dec) st_cnt_d = st_cnt_q - 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    bj_cnt_d = bj_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && id_is_bj && (BJ_BUBBLES != 0)) begin
          state_d  = BUBBLE;
          bj_cnt_d = BJ_LOAD;
        end
      end
      BUBBLE: begin
        if (bj_cnt_q == '0) state_d  = IDLE;
        else                bj_cnt_d = bj_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      bj_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bj_cnt_q  <= '0;
      busy_q    <= '0;
      st_cnt_q  <= '0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bj_cnt_q  <= bj_cnt_d;
      busy_q    <= busy_d;
      st_cnt_q  <= st_cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  // Causes may overlap; each counter sees only its own cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_raw_cnt    <= '0;
      perf_struct_cnt <= '0;
      perf_bj_cnt     <= '0;
    end else begin
      if (raw_risk && (perf_raw_cnt != '1))
        perf_raw_cnt <= perf_raw_cnt + 32'd1;
      if ((md_struct || st_struct || fence_stall) && (perf_struct_cnt != '1))
        perf_struct_cnt <= perf_struct_cnt + 32'd1;
      if ((state_q == BUBBLE) && (perf_bj_cnt != '1))
        perf_bj_cnt <= perf_bj_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard (BJ_BUBBLES=2). The driver sets
//   inputs just after a rising edge and queues the outputs expected for that
//   cycle; the monitor pops and compares on the following falling edge.
module tb_hazard_scoreboard;

  logic        clk, rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wen;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_cls;
  logic        id_is_bj, id_is_store, id_is_fence_i;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_addr;
  logic        md_done, st_retire, flush;
  logic        pipe_stall, raw_risk, sb_full;
  logic [31:0] busy_vec;

  hazard_scoreboard #(
    .RF_ADDR_WIDTH(5), .NUM_WB(2), .SB_DEPTH(4), .BJ_BUBBLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .id_cls(id_cls), .id_is_bj(id_is_bj), .id_is_store(id_is_store),
    .id_is_fence_i(id_is_fence_i), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .md_done(md_done), .st_retire(st_retire), .flush(flush),
    .pipe_stall(pipe_stall), .raw_risk(raw_risk), .sb_full(sb_full),
    .busy_vec(busy_vec)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        raw;
    logic        full;
    logic [31:0] busy;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        m = q.pop_front();
        checks++;
        if ({pipe_stall, raw_risk, sb_full, busy_vec} !== {m.stall, m.raw, m.full, m.busy}) begin
          failures++;
          $display("FAIL %s: got stall=%0b raw=%0b full=%0b busy=%h, expected stall=%0b raw=%0b full=%0b busy=%h",
                   m.name, pipe_stall, raw_risk, sb_full, busy_vec, m.stall, m.raw, m.full, m.busy);
        end
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rd_wen = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_cls = 0;
    id_is_bj = 0; id_is_store = 0; id_is_fence_i = 0;
    wb_valid = 0; wb_addr = 0; md_done = 0; st_retire = 0; flush = 0;
  endtask

  task automatic ins(input logic [1:0] c, input logic [4:0] rd, input logic wen);
    id_valid = 1; id_cls = c; id_rd = rd; id_rd_wen = wen;
  endtask

  task automatic chk(input string n, input logic s, input logic r, input logic f,
                     input logic [31:0] b);
    exp_t e;
    e.name = n; e.stall = s; e.raw = r; e.full = f; e.busy = b;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 0, 0, 32'h0);
    rst = 0;

    // LOAD rd=5 then a reader of x5
    clr(); ins(1, 5, 1);                      chk("load5_issue", 0, 0, 0, 32'h0);
    clr(); ins(0, 6, 1); id_rs1 = 5; id_rs1_used = 1;
                                              chk("raw_rs1", 1, 1, 0, 32'h20);
    wb_valid = 2'b01; wb_addr = {5'd0, 5'd5}; chk("raw_held_on_wb", 1, 1, 0, 32'h20);
    wb_valid = 2'b00;                         chk("raw_released", 0, 0, 0, 32'h0);

    // WAW via rd, cleared through port 1
    clr(); ins(1, 9, 1);                      chk("load9_issue", 0, 0, 0, 32'h0);
    clr(); ins(0, 9, 1);                      chk("waw", 1, 1, 0, 32'h200);
    clr(); wb_valid = 2'b10; wb_addr = {5'd9, 5'd0};
                                              chk("wb1_clear_cycle", 0, 0, 0, 32'h200);
    clr();                                    chk("wb1_cleared", 0, 0, 0, 32'h0);

    // Unused operands do not hazard; rs2 does
    clr(); ins(1, 8, 1);                      chk("load8_issue", 0, 0, 0, 32'h0);
    clr(); ins(0, 1, 0); id_rs1 = 8; id_rs2 = 8;
                                              chk("unused_no_haz", 0, 0, 0, 32'h100);
    clr(); ins(0, 1, 0); id_rs2 = 8; id_rs2_used = 1;
                                              chk("raw_rs2", 1, 1, 0, 32'h100);
    wb_valid = 2'b01; wb_addr = {5'd0, 5'd8}; chk("raw_rs2_wb", 1, 1, 0, 32'h100);
    clr();                                    chk("rs2_cleared", 0, 0, 0, 32'h0);

    // x0 never busy
    clr(); ins(1, 0, 1);                      chk("load_x0_issue", 0, 0, 0, 32'h0);
    clr();                                    chk("x0_never_busy", 0, 0, 0, 32'h0);

    // mul/div structural hazard
    clr(); ins(2, 3, 1);                      chk("mul3_issue", 0, 0, 0, 32'h0);
    clr(); ins(3, 4, 1);                      chk("md_struct", 1, 0, 0, 32'h8);
    md_done = 1; wb_valid = 2'b01; wb_addr = {5'd0, 5'd3};
                                              chk("md_done_cycle", 1, 0, 0, 32'h8);
    md_done = 0; wb_valid = 2'b00;            chk("div_accepted", 0, 0, 0, 32'h0);
    clr(); md_done = 1; wb_valid = 2'b01; wb_addr = {5'd0, 5'd4};
                                              chk("div_done", 0, 0, 0, 32'h10);
    clr(); ins(2, 6, 1); md_done = 1;         chk("mul_with_done", 0, 0, 0, 32'h0);
    clr(); ins(3, 0, 0);                      chk("md_set_wins", 1, 0, 0, 32'h40);
    md_done = 1; wb_valid = 2'b01; wb_addr = {5'd0, 5'd6};
                                              chk("md_set_wins_done", 1, 0, 0, 32'h40);
    clr();                                    chk("md_idle", 0, 0, 0, 32'h0);

    // Store buffer fill and retire
    for (int i = 0; i < 4; i++) begin
      clr(); id_valid = 1; id_is_store = 1;   chk("store_fill", 0, 0, 0, 32'h0);
    end
    clr(); id_valid = 1; id_is_store = 1;     chk("sb_full_stall", 1, 0, 1, 32'h0);
    st_retire = 1;                            chk("sb_full_retire", 1, 0, 1, 32'h0);
    st_retire = 0;                            chk("store_after_retire", 0, 0, 0, 32'h0);
    clr(); st_retire = 1;                     chk("full_again", 0, 0, 1, 32'h0);
    clr(); id_valid = 1; id_is_store = 1; st_retire = 1;
                                              chk("store_and_retire", 0, 0, 0, 32'h0);
    clr();                                    chk("count_unchanged", 0, 0, 0, 32'h0);
    clr(); st_retire = 1;                     chk("retire_to_two", 0, 0, 0, 32'h0);

    // fence.i waits for the store count to drain (count is 2 here)
    clr(); id_valid = 1; id_is_fence_i = 1;   chk("fence_cnt2", 1, 0, 0, 32'h0);
    st_retire = 1;                            chk("fence_retire1", 1, 0, 0, 32'h0);
                                              chk("fence_retire2", 1, 0, 0, 32'h0);
    st_retire = 0;                            chk("fence_proceeds", 0, 0, 0, 32'h0);
    clr(); st_retire = 1;                     chk("retire_at_zero", 0, 0, 0, 32'h0);
    clr(); id_valid = 1; id_is_fence_i = 1;   chk("fence_no_wrap", 0, 0, 0, 32'h0);

    // Branch bubbles
    clr(); id_valid = 1; id_is_bj = 1;        chk("bj_accept", 0, 0, 0, 32'h0);
    clr();                                    chk("bubble1", 1, 0, 0, 32'h0);
                                              chk("bubble2", 1, 0, 0, 32'h0);
                                              chk("bubble_done", 0, 0, 0, 32'h0);
    clr(); id_valid = 1; id_is_bj = 1;        chk("bj2_accept", 0, 0, 0, 32'h0);
    clr(); flush = 1;                         chk("flush_in_bubble", 1, 0, 0, 32'h0);
    clr();                                    chk("flush_ends_bubble", 0, 0, 0, 32'h0);
    clr(); id_valid = 1; id_is_bj = 1; flush = 1;
                                              chk("bj_flushed", 0, 0, 0, 32'h0);
    clr();                                    chk("no_bubble_after_flush", 0, 0, 0, 32'h0);

    // flush keeps the scoreboard
    clr(); ins(1, 10, 1);                     chk("load10_issue", 0, 0, 0, 32'h0);
    clr(); flush = 1;                         chk("flush_keeps_busy", 0, 0, 0, 32'h400);
    clr();                                    chk("busy_after_flush", 0, 0, 0, 32'h400);

    // set wins over a double clear of the same register; ALU rd=0 changes nothing
    clr(); ins(1, 7, 1); wb_valid = 2'b11; wb_addr = {5'd7, 5'd7};
                                              chk("set_vs_clr", 0, 0, 0, 32'h400);
    clr(); ins(0, 0, 1);                      chk("set_wins", 0, 0, 0, 32'h480);
    clr(); wb_valid = 2'b11; wb_addr = {5'd10, 5'd7};
                                              chk("alu_x0_unchanged", 0, 0, 0, 32'h480);
    clr();                                    chk("all_cleared", 0, 0, 0, 32'h0);

    // Asynchronous reset mid-operation
    clr(); ins(1, 12, 1);                     chk("load12_issue", 0, 0, 0, 32'h0);
    clr(); id_valid = 1; id_is_store = 1;     chk("store_before_rst", 0, 0, 0, 32'h1000);
    clr();
    rst = 1;
    #2;
    rst = 0;
    id_valid = 1; id_is_fence_i = 1;          chk("async_reset", 0, 0, 0, 32'h0);
    clr();

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
